// File: rtl/control_fsm.sv
// Multi-cycle control FSM for the copperv core: fetch/memory bus timeouts, external
// mul/div handshake, illegal-instruction trap and a retired-instruction counter.
module control_fsm #(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned MULDIV_EN     = 1,
    parameter int unsigned INSTRET_WIDTH = 32,
    parameter int unsigned TMO_WIDTH     = 8,
    localparam int unsigned INST_TYPE_WIDTH    = 4,
    localparam int unsigned ALU_COMP_WIDTH     = 3,
    localparam int unsigned FUNCT_WIDTH        = 4,
    localparam int unsigned RD_DIN_SEL_WIDTH   = 2,
    localparam int unsigned PC_NEXT_SEL_WIDTH  = 2,
    localparam int unsigned ALU_DIN1_SEL_WIDTH = 1,
    localparam int unsigned ALU_DIN2_SEL_WIDTH = 2,
    localparam int unsigned ALU_OP_WIDTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INST_TYPE_WIDTH-1:0]    inst_type_i,
    input  logic                          inst_valid_i,
    input  logic [ALU_COMP_WIDTH-1:0]     alu_comp_i,
    input  logic [FUNCT_WIDTH-1:0]        funct_i,
    input  logic                          muldiv_i,
    input  logic                          data_valid_i,
    input  logic                          ext_busy_i,
    output logic                          inst_fetch_o,
    output logic                          store_data_o,
    output logic                          load_data_o,
    output logic                          ext_start_o,
    output logic                          rd_en_o,
    output logic                          rs1_en_o,
    output logic                          rs2_en_o,
    output logic [RD_DIN_SEL_WIDTH-1:0]   rd_din_sel_o,
    output logic [PC_NEXT_SEL_WIDTH-1:0]  pc_next_sel_o,
    output logic [ALU_DIN1_SEL_WIDTH-1:0] alu_din1_sel_o,
    output logic [ALU_DIN2_SEL_WIDTH-1:0] alu_din2_sel_o,
    output logic [ALU_OP_WIDTH-1:0]       alu_op_o,
    output logic                          trap_o,
    output logic [1:0]                    trap_cause_o,
    output logic                          retire_o,
    output logic [INSTRET_WIDTH-1:0]      instret_o
);

    localparam logic [3:0] InstImm = 4'd0, InstIntImm = 4'd1, InstIntReg = 4'd2,
                           InstBranch = 4'd3, InstStore = 4'd4, InstLoad = 4'd5,
                           InstJal = 4'd6, InstJalr = 4'd7, InstAuipc = 4'd8, InstFence = 4'd9;
    localparam logic [3:0] FunctAdd = 4'd0, FunctSub = 4'd1, FunctSll = 4'd2, FunctSlt = 4'd3,
                           FunctSltu = 4'd4, FunctXor = 4'd5, FunctSrl = 4'd6, FunctSra = 4'd7,
                           FunctOr = 4'd8, FunctAnd = 4'd9, FunctEq = 4'd10, FunctNeq = 4'd11,
                           FunctLt = 4'd12, FunctGte = 4'd13, FunctLtu = 4'd14,
                           FunctGteu = 4'd15;
    localparam logic [1:0] RdDinSelImm = 2'd0, RdDinSelAlu = 2'd1, RdDinSelMem = 2'd2,
                           RdDinSelExt = 2'd3;
    localparam logic [1:0] PcNextSelStall = 2'd0, PcNextSelIncr = 2'd1,
                           PcNextSelAddImm = 2'd2, PcNextSelAddRs1Imm = 2'd3;
    localparam logic       AluDin1SelRs1 = 1'b0, AluDin1SelPc = 1'b1;
    localparam logic [1:0] AluDin2SelImm = 2'd0, AluDin2SelRs2 = 2'd1, AluDin2SelConst4 = 2'd2;
    localparam logic [3:0] AluOpNop = 4'd0, AluOpAdd = 4'd1, AluOpSub = 4'd2, AluOpSll = 4'd3,
                           AluOpSlt = 4'd4, AluOpSltu = 4'd5, AluOpXor = 4'd6, AluOpSrl = 4'd7,
                           AluOpSra = 4'd8, AluOpOr = 4'd9, AluOpAnd = 4'd10;
    localparam logic [1:0] CauseFetch = 2'd0, CauseMem = 2'd1, CauseIllegal = 2'd2;

    localparam bit MuldivOn   = (MULDIV_EN != 0);
    localparam bit FetchTmoOn = (FETCH_TIMEOUT != 0);
    localparam bit MemTmoOn   = (MEM_TIMEOUT != 0);
    localparam logic [TMO_WIDTH-1:0] FetchLimit =
        TMO_WIDTH'(FetchTmoOn ? FETCH_TIMEOUT - 1 : 0);
    localparam logic [TMO_WIDTH-1:0] MemLimit = TMO_WIDTH'(MemTmoOn ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        StReset, StFetch, StDecode, StExec, StExecWait, StMem, StTrap
    } state_e;

    state_e                   state_q, state_d;
    logic                     entry_q;
    logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;
    logic [1:0]               trap_cause_q, trap_cause_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     fetch_tmo, mem_tmo, is_load;

    function automatic logic [3:0] funct_alu_op(input logic [3:0] f);
        case (f)
            FunctAdd:  return AluOpAdd;
            FunctSub:  return AluOpSub;
            FunctSll:  return AluOpSll;
            FunctSlt:  return AluOpSlt;
            FunctSltu: return AluOpSltu;
            FunctXor:  return AluOpXor;
            FunctSrl:  return AluOpSrl;
            FunctSra:  return AluOpSra;
            FunctOr:   return AluOpOr;
            FunctAnd:  return AluOpAnd;
            default:   return AluOpNop;
        endcase
    endfunction

    // alu_comp bit 0 = EQ, bit 1 = LT (signed), bit 2 = LTU.
    function automatic logic branch_taken(input logic [3:0] f, input logic [2:0] c);
        case (f)
            FunctEq:   return c[0];
            FunctNeq:  return ~c[0];
            FunctLt:   return c[1];
            FunctGte:  return ~c[1];
            FunctLtu:  return c[2];
            FunctGteu: return ~c[2];
            default:   return 1'b0;
        endcase
    endfunction

    assign fetch_tmo    = FetchTmoOn && (tmo_q == FetchLimit);
    assign mem_tmo      = MemTmoOn && (tmo_q == MemLimit);
    assign is_load      = (inst_type_i == InstLoad);
    assign retire_o     = (pc_next_sel_o != PcNextSelStall);
    assign trap_cause_o = trap_cause_q;
    assign instret_o    = instret_q;

    always_comb begin
        state_d        = state_q;
        trap_cause_d   = trap_cause_q;
        inst_fetch_o   = 1'b0;
        store_data_o   = 1'b0;
        load_data_o    = 1'b0;
        ext_start_o    = 1'b0;
        rd_en_o        = 1'b0;
        rs1_en_o       = 1'b0;
        rs2_en_o       = 1'b0;
        rd_din_sel_o   = RdDinSelImm;
        pc_next_sel_o  = PcNextSelStall;
        alu_din1_sel_o = AluDin1SelRs1;
        alu_din2_sel_o = AluDin2SelImm;
        alu_op_o       = AluOpNop;
        trap_o         = 1'b0;
        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                inst_fetch_o = entry_q;
                if (inst_valid_i) begin
                    state_d = (inst_type_i == InstJal) ? StExec : StDecode;
                end else if (fetch_tmo) begin
                    state_d      = StTrap;
                    trap_cause_d = CauseFetch;
                end
            end
            StDecode: begin
                state_d = StExec;
                case (inst_type_i)
                    InstImm: begin
                        rd_en_o       = 1'b1;
                        rd_din_sel_o  = RdDinSelImm;
                        pc_next_sel_o = PcNextSelIncr;
                        state_d       = StFetch;
                    end
                    InstFence: begin
                        pc_next_sel_o = PcNextSelIncr;
                        state_d       = StFetch;
                    end
                    InstIntImm, InstJalr, InstLoad: rs1_en_o = 1'b1;
                    InstAuipc, InstJal: ;
                    InstIntReg: begin
                        if (muldiv_i && !MuldivOn) begin
                            state_d      = StTrap;
                            trap_cause_d = CauseIllegal;
                        end else begin
                            rs1_en_o = 1'b1;
                            rs2_en_o = 1'b1;
                        end
                    end
                    InstBranch, InstStore: begin
                        rs1_en_o = 1'b1;
                        rs2_en_o = 1'b1;
                    end
                    default: begin
                        state_d      = StTrap;
                        trap_cause_d = CauseIllegal;
                    end
                endcase
            end
            StExec: begin
                state_d = StFetch;
                case (inst_type_i)
                    InstIntImm, InstIntReg: begin
                        alu_din2_sel_o = (inst_type_i == InstIntReg) ? AluDin2SelRs2
                                                                     : AluDin2SelImm;
                        alu_op_o = funct_alu_op(funct_i);
                        if (inst_type_i == InstIntReg && muldiv_i && MuldivOn) begin
                            ext_start_o = entry_q;
                            state_d     = StExecWait;
                        end else begin
                            rd_en_o       = 1'b1;
                            rd_din_sel_o  = RdDinSelAlu;
                            pc_next_sel_o = PcNextSelIncr;
                        end
                    end
                    InstBranch: begin
                        alu_din2_sel_o = AluDin2SelRs2;
                        pc_next_sel_o  = branch_taken(funct_i, alu_comp_i) ? PcNextSelAddImm
                                                                           : PcNextSelIncr;
                    end
                    InstStore, InstLoad: begin
                        alu_op_o = AluOpAdd;
                        state_d  = StMem;
                    end
                    InstJal, InstJalr: begin
                        alu_din1_sel_o = AluDin1SelPc;
                        alu_din2_sel_o = AluDin2SelConst4;
                        alu_op_o       = AluOpAdd;
                        rd_en_o        = 1'b1;
                        rd_din_sel_o   = RdDinSelAlu;
                        pc_next_sel_o  = (inst_type_i == InstJal) ? PcNextSelAddImm
                                                                  : PcNextSelAddRs1Imm;
                    end
                    InstAuipc: begin
                        alu_din1_sel_o = AluDin1SelPc;
                        alu_op_o       = AluOpAdd;
                        rd_en_o        = 1'b1;
                        rd_din_sel_o   = RdDinSelAlu;
                        pc_next_sel_o  = PcNextSelIncr;
                    end
                    default: ;
                endcase
            end
            StExecWait: begin
                // Unit latency is at least one cycle, so busy is not sampled on entry.
                if (!entry_q && !ext_busy_i) begin
                    rd_en_o       = 1'b1;
                    rd_din_sel_o  = RdDinSelExt;
                    pc_next_sel_o = PcNextSelIncr;
                    state_d       = StFetch;
                end
            end
            StMem: begin
                alu_op_o     = AluOpAdd;
                load_data_o  = entry_q & is_load;
                store_data_o = entry_q & ~is_load;
                if (data_valid_i) begin
                    pc_next_sel_o = PcNextSelIncr;
                    rd_en_o       = is_load;
                    rd_din_sel_o  = is_load ? RdDinSelMem : RdDinSelImm;
                    state_d       = StFetch;
                end else if (mem_tmo) begin
                    state_d      = StTrap;
                    trap_cause_d = CauseMem;
                end
            end
            StTrap: begin
                trap_o  = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if ((state_q == StFetch || state_q == StMem) && tmo_q != {TMO_WIDTH{1'b1}}) begin
            tmo_d = tmo_q + 1'b1;
        end
        instret_d = instret_q + INSTRET_WIDTH'(retire_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StReset;
            entry_q      <= 1'b0;
            tmo_q        <= '0;
            trap_cause_q <= 2'd0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            entry_q      <= (state_d != state_q);
            tmo_q        <= tmo_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Parametrised multi-cycle control FSM for the copperv core; successor to the existing single-path control unit.
- Drives the same datapath select/enable fields (encodings from copperv_h.v).
- Adds three things:
  - fetch/memory bus timeouts with a trap state
  - a variable-latency external execute unit (mul/div) handshake
  - an illegal-instruction trap and a retired-instruction counter.
- Sits between the decoder/ALU and the register file, PC and bus adapters.

Parameters:
- FETCH_TIMEOUT, 16, max cycles waiting for inst_valid in FETCH; 0 disables the timeout.
- MEM_TIMEOUT, 16, max cycles waiting for data_valid in MEM; 0 disables the timeout.
- MULDIV_EN, 1, 1 = external execute unit present; 0 = muldiv instructions trap as illegal.
- INSTRET_WIDTH, 32, width of the retired-instruction counter.
- TMO_WIDTH, 8, timeout counter width; must hold max(FETCH_TIMEOUT, MEM_TIMEOUT).

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- inst_type in INST_TYPE_WIDTH: decoded instruction class.
- inst_valid in 1: fetched instruction valid.
- alu_comp in ALU_COMP_WIDTH: EQ/LT/LTU comparison flags.
- funct in FUNCT_WIDTH: decoded function.
- muldiv in 1: INT_REG instruction belongs to the external unit.
- data_valid in 1: load/store completion.
- ext_busy in 1: external unit still computing.
- inst_fetch out 1: fetch request pulse.
- store_data out 1: store request pulse.
- load_data out 1: load request pulse.
- ext_start out 1: external unit start pulse.
- rd_en, rs1_en, rs2_en out 1 each: register file enables.
- rd_din_sel out RD_DIN_SEL_WIDTH: rd source; adds RD_DIN_SEL_EXT.
- pc_next_sel out PC_NEXT_SEL_WIDTH: next-PC source.
- alu_din1_sel out ALU_DIN1_SEL_WIDTH: ALU operand 1 select.
- alu_din2_sel out ALU_DIN2_SEL_WIDTH: ALU operand 2 select.
- alu_op out ALU_OP_WIDTH: ALU operation.
- trap out 1: one-cycle trap pulse.
- trap_cause out 2: 0 = fetch timeout, 1 = mem timeout, 2 = illegal; held until the next trap.
- retire out 1: instruction-completed pulse.
- instret out INSTRET_WIDTH: retired-instruction count.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RESET, entry flag=0, timeout counter=0, instret=0, trap_cause=0.
  - All outputs 0, pc_next_sel=PC_NEXT_SEL_STALL, alu_op=ALU_OP_NOP.
  - rst asserted mid-operation aborts immediately; no pulse completes.
- States: RESET, FETCH, DECODE, EXEC, EXEC_WAIT, MEM, TRAP. Registered state; outputs combinational from state plus inputs.
- Entry flag: registered (state != state_next), so it is 1 exactly in the first cycle of each newly entered state.
  - inst_fetch, load_data, store_data and ext_start equal the entry flag in their states, giving one pulse per visit.
- RESET → FETCH unconditionally after reset deasserts.
- FETCH:
  - inst_valid: JAL → EXEC, others → DECODE.
  - Else, if FETCH_TIMEOUT != 0 and the counter has reached FETCH_TIMEOUT-1: → TRAP, cause 0.
  - inst_valid in the same cycle as the limit wins (no trap).
- DECODE:
  - IMM and FENCE complete here: IMM sets rd_en, RD_DIN_SEL_IMM, PC_NEXT_SEL_INCR; FENCE sets INCR only. Next state FETCH.
  - Other known types: rs1_en/rs2_en as the type requires, then → EXEC.
  - Unknown inst_type: → TRAP, cause 2.
  - INT_REG with muldiv=1 and MULDIV_EN=0: → TRAP, cause 2.
- EXEC: operand selects, alu_op and branch decision per type, identical to the current control unit.
  - STORE/LOAD → MEM.
  - INT_REG with muldiv=1: ext_start pulse, → EXEC_WAIT.
  - Others → FETCH.
- EXEC_WAIT:
  - Stay while ext_busy, with pc_next_sel=STALL.
  - First cycle with ext_busy=0: rd_en=1, RD_DIN_SEL_EXT, PC_NEXT_SEL_INCR, → FETCH.
  - ext_busy is ignored in the entry cycle (unit latency ≥1).
- MEM:
  - data_valid: PC_NEXT_SEL_INCR; LOAD additionally sets rd_en with RD_DIN_SEL_MEM; → FETCH.
  - Else, if MEM_TIMEOUT != 0 and the counter has reached MEM_TIMEOUT-1: → TRAP, cause 1. data_valid at the limit wins.
- TRAP:
  - Single cycle: trap=1, all enables 0, pc_next_sel=STALL, → FETCH.
  - The datapath loads the trap vector on trap.
- Timeout counter: cleared on every state entry; increments each non-entry cycle in FETCH or MEM; saturates at the maximum value.
- retire:
  - Asserts in every cycle where pc_next_sel != STALL, i.e. the completion cycle.
  - Never asserts in TRAP.
  - instret increments by 1 on retire and wraps modulo 2^INSTRET_WIDTH.

Test Plan:
- rst pulse, then an IMM instruction with inst_valid on cycle 2 → inst_fetch one pulse; rd_en and retire one cycle in DECODE; instret=1.
- FETCH_TIMEOUT=4, inst_valid held 0 → trap=1 on the 5th cycle after FETCH entry with trap_cause=0; inst_fetch re-pulses the next cycle.
- LOAD with data_valid exactly at the timeout cycle (cycle 4 in MEM, MEM_TIMEOUT=4) → no trap; rd_en=1 with RD_DIN_SEL_MEM; retire=1.
- INT_REG with muldiv=1, ext_busy high for 5 cycles → ext_start one pulse; 5 stall cycles; then rd_en with RD_DIN_SEL_EXT and INCR.
- Same instruction with MULDIV_EN=0 → TRAP from DECODE with trap_cause=2; instret unchanged.
- INSTRET_WIDTH=4 with 17 retired IMM instructions → instret=1 (wrap); rst asserted mid-MEM → outputs zero within the same cycle.
